// File: rtl/uart_rx_oversampled.sv
`default_nettype none
// uart_rx_oversampled: oversampled UART receiver with 3-sample majority vote, runtime parity,
// per-word error tags and a first-word-fall-through receive FIFO driving RTS flow control.
module uart_rx_oversampled #(
   parameter int SYSCLK_RATE = 100000000,
   parameter int BAUD_RATE   = 9600,
   parameter int OVERSAMPLE  = 16,
   parameter int DATA_BITS   = 8,
   parameter int STOP_BITS   = 2,
   parameter int MSB_FIRST   = 1,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                        Clk,
   input  logic                        Rst,
   input  logic                        Rx,
   input  logic [1:0]                  Parity_Mode,
   input  logic                        Read_Done,
   input  logic                        Clear_Err,
   output logic [DATA_BITS-1:0]        Data_Out,
   output logic [2:0]                  Rx_Error,
   output logic                        Data_Rdy,
   output logic                        FIFO_Empty,
   output logic                        FIFO_Full,
   output logic                        FIFO_Overflow,
   output logic [$clog2(FIFO_DEPTH):0] FIFO_Count,
   output logic                        RTS
);

   localparam int DIV_RAW = SYSCLK_RATE / (BAUD_RATE * OVERSAMPLE);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SUB_W   = $clog2(OVERSAMPLE);
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int ENT_W   = DATA_BITS + 3;

   localparam logic [SUB_W-1:0] SUB_A     = SUB_W'(OVERSAMPLE/2 - 1);
   localparam logic [SUB_W-1:0] SUB_B     = SUB_W'(OVERSAMPLE/2);
   localparam logic [SUB_W-1:0] SUB_V     = SUB_W'(OVERSAMPLE/2 + 1);
   localparam logic [SUB_W-1:0] SUB_END   = SUB_W'(OVERSAMPLE - 1);
   localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);
   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] HALF_C    = CNT_W'(FIFO_DEPTH/2);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_START      = 3'd1,
      S_DATA       = 3'd2,
      S_PARITY     = 3'd3,
      S_STOP       = 3'd4,
      S_BREAK_WAIT = 3'd5
   } state_t;

   state_t               state, state_next;
   logic [DIV_W-1:0]     div_cnt;
   logic                 tick;
   logic                 rx_meta, rx_sync;
   logic [SUB_W-1:0]     sub_cnt;
   logic [3:0]           bit_cnt;
   logic                 samp_a, samp_b, vote, vote_tick, bit_end;
   logic [DATA_BITS-1:0] shift;
   logic [1:0]           mode_lat;
   logic                 par_en, par_err, frame_err, all_zero;
   logic                 push;
   logic [ENT_W-1:0]     push_entry;

   assign tick = (div_cnt == DIV_W'(DIV - 1));

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst)      div_cnt <= '0;
      else if (tick) div_cnt <= '0;
      else           div_cnt <= div_cnt + 1'b1;
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= Rx;
         rx_sync <= rx_meta;
      end
   end

   // Third vote sample is the live synchronised line at the decision tick.
   assign vote      = (samp_a & samp_b) | (samp_a & rx_sync) | (samp_b & rx_sync);
   assign vote_tick = tick && (sub_cnt == SUB_V);
   assign bit_end   = tick && (sub_cnt == SUB_END);
   assign par_en    = (mode_lat == 2'b01) || (mode_lat == 2'b10);

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) state <= S_IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      push       = 1'b0;
      push_entry = '0;
      case (state)
         S_IDLE:
            if (tick && !rx_sync) state_next = S_START;
         S_START:
            if (vote_tick && vote) state_next = S_IDLE;
            else if (bit_end)      state_next = S_DATA;
         S_DATA:
            if (bit_end && bit_cnt == LAST_DATA) state_next = par_en ? S_PARITY : S_STOP;
         S_PARITY:
            if (bit_end) state_next = S_STOP;
         S_STOP:
            if (vote_tick && bit_cnt == LAST_STOP) begin
               push = 1'b1;
               if (all_zero && !vote) begin
                  push_entry = {{DATA_BITS{1'b0}}, 3'b001};
                  state_next = S_BREAK_WAIT;
               end else begin
                  push_entry = {shift, frame_err | ~vote, par_err, 1'b0};
                  state_next = S_IDLE;
               end
            end
         S_BREAK_WAIT:
            if (tick && rx_sync) state_next = S_IDLE;
         default:
            state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         sub_cnt   <= '0;
         bit_cnt   <= '0;
         samp_a    <= 1'b1;
         samp_b    <= 1'b1;
         shift     <= '0;
         mode_lat  <= 2'b00;
         par_err   <= 1'b0;
         frame_err <= 1'b0;
         all_zero  <= 1'b0;
      end else begin
         if (state == S_IDLE || state == S_BREAK_WAIT) sub_cnt <= '0;
         else if (tick) sub_cnt <= (sub_cnt == SUB_END) ? '0 : sub_cnt + 1'b1;

         if (state_next != state) bit_cnt <= '0;
         else if (bit_end)        bit_cnt <= bit_cnt + 1'b1;

         if (tick && sub_cnt == SUB_A) samp_a <= rx_sync;
         if (tick && sub_cnt == SUB_B) samp_b <= rx_sync;

         if (state == S_IDLE && state_next == S_START) begin
            mode_lat  <= Parity_Mode;
            par_err   <= 1'b0;
            frame_err <= 1'b0;
            all_zero  <= 1'b1;
         end

         if (vote_tick) begin
            case (state)
               S_DATA: begin
                  shift    <= (MSB_FIRST != 0) ? {shift[DATA_BITS-2:0], vote}
                                               : {vote, shift[DATA_BITS-1:1]};
                  all_zero <= all_zero & ~vote;
               end
               S_PARITY: begin
                  par_err  <= (^shift) ^ vote ^ (mode_lat == 2'b10);
                  all_zero <= all_zero & ~vote;
               end
               S_STOP: begin
                  if (!vote) frame_err <= 1'b1;
                  all_zero <= all_zero & ~vote;
               end
               default: ;
            endcase
         end
      end
   end

   logic [ENT_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count, count_next;
   logic             empty_r, full_r, ovf_r;
   logic             do_pop, do_push, ovf_set;
   logic [ENT_W-1:0] head;

   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign do_pop  = Read_Done && (count != '0);
   assign do_push = push && ((count != DEPTH_C) || do_pop);
   assign ovf_set = push && (count == DEPTH_C) && !do_pop;

   always_comb begin
      count_next = count;
      if (do_push && !do_pop)      count_next = count + 1'b1;
      else if (!do_push && do_pop) count_next = count - 1'b1;
   end

   always_ff @(posedge Clk) begin
      if (do_push) mem[wr_ptr] <= push_entry;
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         empty_r <= 1'b1;
         full_r  <= 1'b0;
         ovf_r   <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count   <= count_next;
         empty_r <= (count_next == '0);
         full_r  <= (count_next > HALF_C);
         if (ovf_set)        ovf_r <= 1'b1;
         else if (Clear_Err) ovf_r <= 1'b0;
      end
   end

   assign head          = mem[rd_ptr];
   assign Data_Out      = empty_r ? '0 : head[ENT_W-1:3];
   assign Rx_Error      = empty_r ? 3'b000 : head[2:0];
   assign Data_Rdy      = ~empty_r;
   assign FIFO_Empty    = empty_r;
   assign FIFO_Full     = full_r;
   assign FIFO_Overflow = ovf_r;
   assign FIFO_Count    = count;
   assign RTS           = ~full_r;

endmodule
`default_nettype wire

// File: doc/uart_rx_oversampled.md
# uart_rx_oversampled

Parametrised next-generation UART receive path: oversampled start/bit detection with 3-sample majority vote, runtime-selectable parity (none/even/odd), per-word error tagging and a first-word-fall-through receive FIFO with threshold flow control. It replaces the single-rate receiver and FIFO pair behind the UART interface. It feeds the host-side Data_Out/Read_Done port and drives RTS back to the remote transmitter.

## Interface
- SYSCLK_RATE, 100000000, Clk frequency in Hz.
- BAUD_RATE, 9600, line bit rate.
- OVERSAMPLE, 16, ticks per bit; even, ≥8.
- DATA_BITS, 8, data bits per frame; 5..9.
- STOP_BITS, 2, stop bits checked; 1..2.
- MSB_FIRST, 1, 1: first data bit on line is Data_Out[DATA_BITS-1]; 0: LSB first.
- FIFO_DEPTH, 8, entries; power of 2, ≥2.
- Clk  in  1  single system clock; all logic on rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Rx  in  1  serial input; asynchronous, idle high.
- Parity_Mode  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- Read_Done  in  1  pop head entry; one entry per cycle while high and not empty.
- Clear_Err  in  1  one-cycle pulse clears FIFO_Overflow.
- Data_Out  out  DATA_BITS  data of head entry; 0 when empty.
- Rx_Error  out  3  error tag of head entry: [0] break, [1] parity, [2] frame; 0 when empty.
- Data_Rdy  out  1  equals !FIFO_Empty.
- FIFO_Empty  out  1  no entries.
- FIFO_Full  out  1  count > FIFO_DEPTH/2 (half full plus one).
- FIFO_Overflow  out  1  sticky: a word was dropped.
- FIFO_Count  out  $clog2(FIFO_DEPTH)+1  entries held.
- RTS  out  1  equals !FIFO_Full.

## Operation
- Tick generator: DIV = max(1, SYSCLK_RATE/(BAUD_RATE*OVERSAMPLE)), integer floor; one-Clk tick every DIV cycles, free-running.
- Rx passes through a 2-flop synchroniser (reset value 1); all decisions use synchronised Rx.
- Sample point of each bit: majority of samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1 within the bit.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
- IDLE: low seen on a tick -> START; tick counter cleared; Parity_Mode latched.
- START: at mid-bit vote; 1 -> IDLE (glitch, nothing pushed); 0 -> DATA.
- DATA: DATA_BITS bits shifted per MSB_FIRST; -> PARITY if latched mode even/odd, else STOP.
- PARITY: even: XOR(data,parity bit) must be 0; odd: must be 1; mismatch sets parity tag.
- STOP: STOP_BITS bits; any stop bit voted 0 sets frame tag. After last stop sample: push entry, -> IDLE (or BREAK_WAIT, below).
- Break: start, all data, parity (if enabled) and all stop bits voted 0 -> push data 0 with tag 001 only (parity/frame suppressed), -> BREAK_WAIT; stays until Rx high on a tick, then IDLE.
- Entries with parity/frame errors are pushed with data as received.
- FIFO: width DATA_BITS+3, FWFT; head always presented on Data_Out/Rx_Error.
- Push when count == FIFO_DEPTH and no pop: word dropped, FIFO_Overflow set. Push and pop same cycle when full: both occur, no overflow. Pop when empty: ignored. Push and pop same cycle when empty: push only.
- Pointers wrap modulo FIFO_DEPTH; count never exceeds FIFO_DEPTH.
- Clear_Err and overflow-set in same cycle: set wins.

## Timing
- Reset values: Data_Out 0, Rx_Error 0, Data_Rdy 0, FIFO_Empty 1, FIFO_Full 0, FIFO_Overflow 0, FIFO_Count 0, RTS 1; FSM IDLE, FIFO cleared.
- Rx to synchronised Rx: 2 Clk.
- Push: entry visible (Data_Rdy=1, count+1) on the Clk after the tick taking the last stop-bit vote.
- Pop: Read_Done sampled at edge N; new head, count, flags valid after edge N.
- FIFO_Full/RTS/FIFO_Empty registered from count; update same edge as count.
- Rst assertion mid-frame: partial frame discarded, outputs to reset values immediately.
- Parity_Mode changes mid-frame affect next frame only.

## Test plan
- Params SYSCLK_RATE=16*BAUD_RATE (DIV=1), defaults; Parity_Mode=01; send 0xA5, parity 0, 2 stop -> Data_Rdy=1, Data_Out=0xA5, Rx_Error=000; Read_Done 1 cycle -> FIFO_Empty=1.
- Same frame with inverted parity bit -> Data_Out=0xA5, Rx_Error=010; Parity_Mode=10 with correct even parity -> 010; Parity_Mode=00, 10-bit frame -> 000.
- Stop bits driven 0, data 0xAA -> Rx_Error=100, Data_Out=0xAA; Rx held low 12 bit times then high -> one entry 0x00 with 001, no further entries until line returns high.
- Send words 0..4 without reading -> FIFO_Full=1, RTS=0 after 5th; send 3 more (0..7) -> count 8; 9th -> FIFO_Overflow=1, count 8; read 8 -> Data_Out sequence 0..7; Clear_Err -> overflow 0.
- 1-bit-time/4 low glitch on idle Rx -> no entry; single-tick glitch inside data bit 3 of 0x00 -> majority vote gives 0x00.
- Rst low mid-data-bit of a frame -> all outputs at reset values; next clean frame 0x3C received correctly.
